rv32i_control_sequencer: RTL
============================

# rv32i_control_sequencer

Multi-cycle fetch/decode/sequence controller that drives `datapathunit`. It owns the program counter and fetches instruction words over a request/valid handshake. Each instruction is decoded into the register numbers, ALU select, immediates and control strobes that the datapath consumes. The branch flags the datapath returns (`beq`, `bneq`, `bgeq`, `blt`) select the next PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- imem_addr  out  32  current PC; reset RESET_PC.
- imem_req  out  1  fetch request; reset 0.
- imem_valid  in  1  instruction word valid; qualifies imem_rdata.
- imem_rdata  in  32  instruction word.
- read_reg_num1, read_reg_num2, write_reg_num  out  5 each  rs1, rs2, rd; reset 0.
- alu_cntrl  out  6  ALU select; reset 0.
- jump, beq_cntrl, bneq_cntrl, bgeq_cntrl, blt_cntrl, lui_cntrl, lb, sw, mem_to_reg, reg_dst  out  1 each  control strobes; reset 0.
- imm_val, shamt, imm_val_lui, imm_val_jump, return_address  out  32 each  decoded operands; reset 0.
- beq, bneq, bgeq, blt  in  1 each  branch-taken flags from datapath.
- retire  out  1  one-cycle pulse per committed instruction; reset 0.
- illegal  out  1  sticky trap flag; reset 0.

## Operation
- FSM states: FETCH, DECODE, EXEC, COMMIT, TRAP. Reset state is FETCH.
- FETCH:
  - imem_req=1 and imem_addr=PC.
  - On imem_valid=1, latch imem_rdata into IR and go to DECODE.
  - imem_valid is ignored in every state other than FETCH.
- DECODE:
  - Register all decoded outputs from IR. Strobes stay 0.
  - An unsupported opcode or funct3 goes to TRAP; otherwise go to EXEC.
- Supported instructions:
  - OP (0110011): ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - OP-IMM (0010011): ADDI, ANDI, ORI, XORI, SLLI, SRLI, SRAI, SLTI.
  - LUI, LB (funct3 000), SW (funct3 010), JAL.
  - BEQ, BNE, BGE, BLT (funct3 000, 001, 101, 100).
- alu_cntrl encoding:
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU.
  - Immediate forms use the same code +16.
  - Branch compares: 12 EQ, 13 NE, 14 GE, 15 LT.
- Operand fields:
  - imm_val = sign-extended I- or S-immediate.
  - shamt = zero-extended IR[24:20].
  - imm_val_lui = {IR[31:12], 12'b0}.
  - imm_val_jump = sign-extended J-immediate.
  - return_address = PC+4.
  - reg_dst=1 for R/I types that write rd.
- EXEC:
  - Assert the decoded strobes for exactly one cycle: jump for JAL, lui_cntrl, lb plus mem_to_reg, sw, and the relevant branch *_cntrl.
  - Go to COMMIT.
- COMMIT: sample the branch flags, compute next PC, pulse retire, go to FETCH.
  - JAL: next = PC + imm_val_jump.
  - Branch, where the flag matching the decoded type is 1: next = PC + sign-extended B-immediate.
  - Flags of non-matching types are ignored.
  - All other cases: next = PC+4.
  - Arithmetic is 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- Misaligned target (next[1:0]≠0): go to TRAP instead of FETCH. PC is unchanged and retire is still 0.
- TRAP:
  - illegal=1, imem_req=0, all strobes 0.
  - The FSM stays in TRAP until reset.
- Reset at any state: state=FETCH, PC=RESET_PC, all outputs to reset values. An in-flight fetch is abandoned.

## Timing
- imem_req rises in the first cycle after reset deasserts.
- imem_req stays high until the cycle imem_valid is sampled; it drops the cycle after.
- Valid sampled at edge N means:
  - DECODE runs in cycle N+1.
  - EXEC strobes are high in cycle N+2.
  - retire is high in cycle N+3.
  - The next imem_req, at the new PC, is high in cycle N+4.
- Minimum throughput: 4 cycles per instruction with zero-wait memory.
- Datapath flags must be valid in the COMMIT cycle, i.e. registered from EXEC.
- Decoded fields hold their value from DECODE until the next DECODE.
- Strobes are never high outside EXEC.
- reset and imem_valid in the same cycle: reset wins and the word is dropped.

## Test plan
- Reset, then imem_valid=1 with word 32'h00500093 (ADDI x1,x0,5):
  - Decode: write_reg_num=1, alu_cntrl=17, imm_val=5.
  - retire pulses 3 cycles after valid.
  - imem_addr becomes 4.
- BEQ x1,x2,+8 at PC=0x10:
  - beq=1 in COMMIT → PC=0x18.
  - beq=0 → PC=0x14.
  - bneq=1 alone → PC=0x14 (flag of the wrong type is ignored).
- JAL x1,-4 at PC=0:
  - jump high for one cycle.
  - return_address=4.
  - PC wraps to 32'hFFFF_FFFC.
- Opcode 7'b1110011:
  - illegal=1 in the cycle after DECODE; imem_req stays 0.
  - Only reset clears it, restoring PC=RESET_PC.
- imem_valid held low for 5 cycles in FETCH:
  - imem_req stays high and no strobes fire.
  - Reset asserted at cycle 3 → imem_req=0 for that cycle, then the fetch restarts at PC=0.
- SW x2,12(x1) then LB x3,12(x1):
  - sw strobe high only in the first EXEC; lb and mem_to_reg high only in the second.
  - imm_val=12 for both.

Source files
------------

// File: rtl/rv32i_control_sequencer.sv
// Multi-cycle RV32I fetch/decode/sequence controller driving datapathunit.
// Owns the PC; each instruction walks FETCH -> DECODE -> EXEC -> COMMIT.
module rv32i_control_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  read_reg_num1,
  output logic [4:0]  read_reg_num2,
  output logic [4:0]  write_reg_num,
  output logic [5:0]  alu_cntrl,
  output logic        jump,
  output logic        beq_cntrl,
  output logic        bneq_cntrl,
  output logic        bgeq_cntrl,
  output logic        blt_cntrl,
  output logic        lui_cntrl,
  output logic        lb,
  output logic        sw,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic [31:0] imm_val,
  output logic [31:0] shamt,
  output logic [31:0] imm_val_lui,
  output logic [31:0] imm_val_jump,
  output logic [31:0] return_address,
  input  logic        beq,
  input  logic        bneq,
  input  logic        bgeq,
  input  logic        blt,
  output logic        retire,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, COMMIT, TRAP} state_t;
  typedef enum logic [3:0] {
    K_ALU, K_LUI, K_LB, K_SW, K_JAL, K_BEQ, K_BNE, K_BGE, K_BLT
  } kind_t;

  state_t      state;
  state_t      state_next;
  kind_t       kind;
  kind_t       dec_kind;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] branch_off;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [5:0]  dec_alu;
  logic        dec_reg_dst;
  logic        dec_bad;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic        taken;
  logic [31:0] next_pc;
  logic        misaligned;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign imem_addr = pc;

  assign i_imm = {{20{ir[31]}}, ir[31:20]};
  assign s_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign b_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign j_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // NOTE: every signal written in an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec_kind    = K_ALU;
    dec_alu     = 6'd0;
    dec_reg_dst = 1'b0;
    dec_bad     = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_reg_dst = 1'b1;
        case (funct3)
          3'b000: dec_alu = ir[30] ? 6'd2 : 6'd1;
          3'b001: dec_alu = 6'd6;
          3'b010: dec_alu = 6'd9;
          3'b011: dec_alu = 6'd10;
          3'b100: dec_alu = 6'd5;
          3'b101: dec_alu = ir[30] ? 6'd8 : 6'd7;
          3'b110: dec_alu = 6'd4;
          3'b111: dec_alu = 6'd3;
        endcase
      end
      OPC_OP_IMM: begin
        dec_reg_dst = 1'b1;
        case (funct3)
          3'b000:  dec_alu = 6'd17;
          3'b001:  dec_alu = 6'd22;
          3'b010:  dec_alu = 6'd25;
          3'b100:  dec_alu = 6'd21;
          3'b101:  dec_alu = ir[30] ? 6'd24 : 6'd23;
          3'b110:  dec_alu = 6'd20;
          3'b111:  dec_alu = 6'd19;
          default: dec_bad = 1'b1;
        endcase
      end
      OPC_LUI: dec_kind = K_LUI;
      OPC_LOAD: begin
        dec_kind    = K_LB;
        dec_alu     = 6'd17;
        dec_reg_dst = 1'b1;
        dec_bad     = (funct3 != 3'b000);
      end
      OPC_STORE: begin
        dec_kind = K_SW;
        dec_alu  = 6'd17;
        dec_bad  = (funct3 != 3'b010);
      end
      OPC_JAL: dec_kind = K_JAL;
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  begin dec_kind = K_BEQ; dec_alu = 6'd12; end
          3'b001:  begin dec_kind = K_BNE; dec_alu = 6'd13; end
          3'b101:  begin dec_kind = K_BGE; dec_alu = 6'd14; end
          3'b100:  begin dec_kind = K_BLT; dec_alu = 6'd15; end
          default: dec_bad = 1'b1;
        endcase
      end
      default: dec_bad = 1'b1;
    endcase
  end

  // Only the flag matching the decoded branch type can redirect the PC.
  always_comb begin
    taken = 1'b0;
    case (kind)
      K_JAL:   taken = 1'b1;
      K_BEQ:   taken = beq;
      K_BNE:   taken = bneq;
      K_BGE:   taken = bgeq;
      K_BLT:   taken = blt;
      default: taken = 1'b0;
    endcase
  end

  assign next_pc    = !taken ? pc + 32'd4 :
                      (kind == K_JAL) ? pc + imm_val_jump : pc + branch_off;
  assign misaligned = |next_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Reset forces all combinational outputs low in the reset cycle itself.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    jump       = 1'b0;
    beq_cntrl  = 1'b0;
    bneq_cntrl = 1'b0;
    bgeq_cntrl = 1'b0;
    blt_cntrl  = 1'b0;
    lui_cntrl  = 1'b0;
    lb         = 1'b0;
    sw         = 1'b0;
    mem_to_reg = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_valid) state_next = DECODE;
        end
        DECODE: state_next = dec_bad ? TRAP : EXEC;
        EXEC: begin
          jump       = (kind == K_JAL);
          beq_cntrl  = (kind == K_BEQ);
          bneq_cntrl = (kind == K_BNE);
          bgeq_cntrl = (kind == K_BGE);
          blt_cntrl  = (kind == K_BLT);
          lui_cntrl  = (kind == K_LUI);
          lb         = (kind == K_LB);
          mem_to_reg = (kind == K_LB);
          sw         = (kind == K_SW);
          state_next = COMMIT;
        end
        COMMIT: begin
          if (misaligned) begin
            state_next = TRAP;
          end else begin
            retire     = 1'b1;
            state_next = FETCH;
          end
        end
        TRAP:    illegal = 1'b1;
        default: state_next = FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  // NOTE: IR and decoded fields are reset too, since the fields drive module outputs directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      ir             <= '0;
      kind           <= K_ALU;
      branch_off     <= '0;
      read_reg_num1  <= '0;
      read_reg_num2  <= '0;
      write_reg_num  <= '0;
      alu_cntrl      <= '0;
      reg_dst        <= 1'b0;
      imm_val        <= '0;
      shamt          <= '0;
      imm_val_lui    <= '0;
      imm_val_jump   <= '0;
      return_address <= '0;
    end else begin
      if (state == FETCH && imem_valid) ir <= imem_rdata;
      if (state == DECODE) begin
        kind           <= dec_kind;
        branch_off     <= b_imm;
        read_reg_num1  <= ir[19:15];
        read_reg_num2  <= ir[24:20];
        write_reg_num  <= ir[11:7];
        alu_cntrl      <= dec_alu;
        reg_dst        <= dec_reg_dst;
        imm_val        <= (opcode == OPC_STORE) ? s_imm : i_imm;
        shamt          <= {27'd0, ir[24:20]};
        imm_val_lui    <= {ir[31:12], 12'd0};
        imm_val_jump   <= j_imm;
        return_address <= pc + 32'd4;
      end
      if (state == COMMIT && !misaligned) pc <= next_pc;
    end
  end

endmodule
